// File: rtl/state_display_sync.sv
// Frame-aligned display-state follower: fades out on every game-state change,
// swaps the rendered screen at full black, then fades back in.
package state_display_sync_pkg;
  typedef enum logic [1:0] {
    START   = 2'd0,
    LEVEL_1 = 2'd1,
    FINISH  = 2'd2
  } g_state;
endpackage

module state_display_sync
  import state_display_sync_pkg::*;
#(
  parameter int unsigned FADE_BITS       = 4,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic                 clk_40,
  input  logic                 rst,
  input  g_state               game_state,
  input  logic                 vblnk,
  output g_state               display_state,
  output logic [FADE_BITS-1:0] fade_level,
  output logic                 level_init,
  output logic                 busy
);

  localparam int unsigned CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FADE_BITS-1:0] FADE_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    SWAP,
    FADE_IN
  } fsm_t;

  fsm_t                 r_state, w_state_nxt;
  logic                 r_vblnk_d;
  logic                 w_tick, w_step, w_entry, w_fading;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  g_state               r_target, w_target_nxt;
  g_state               r_disp, w_disp_nxt;
  logic [FADE_BITS-1:0] r_fade, w_fade_nxt;
  logic                 r_init, w_init_nxt;
  logic                 r_busy;

  assign w_tick = vblnk & ~r_vblnk_d;
  assign w_step = w_tick && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_disp_nxt   = r_disp;
    w_fade_nxt   = r_fade;
    w_init_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (game_state != r_disp) begin
          w_target_nxt = game_state;
          w_state_nxt  = FADE_OUT;
        end
      end
      FADE_OUT: begin
        w_target_nxt = game_state;
        // Zero is tested on the registered level, so SWAP follows the final step by one cycle.
        if (r_fade == '0)
          w_state_nxt = SWAP;
        else if (w_step)
          w_fade_nxt = r_fade - 1'b1;
      end
      SWAP: begin
        w_disp_nxt  = r_target;
        w_init_nxt  = (r_target == LEVEL_1) && (r_disp != LEVEL_1);
        w_state_nxt = FADE_IN;
      end
      FADE_IN: begin
        if (r_fade == FADE_MAX)
          w_state_nxt = IDLE;
        else if (w_step)
          w_fade_nxt = r_fade + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Entry into a fade phase clears the counter, discarding a coincident tick.
  always_comb begin
    w_fading = (r_state == FADE_OUT) || (r_state == FADE_IN);
    w_entry  = (w_state_nxt != r_state) &&
               ((w_state_nxt == FADE_OUT) || (w_state_nxt == FADE_IN));
    w_cnt_nxt = r_cnt;
    if (w_entry)
      w_cnt_nxt = '0;
    else if (w_fading && w_tick)
      w_cnt_nxt = w_step ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk_40 or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_vblnk_d <= 1'b0;
      r_cnt     <= '0;
      r_target  <= START;
      r_disp    <= START;
      r_fade    <= FADE_MAX;
      r_init    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vblnk_d <= vblnk;
      r_cnt     <= w_cnt_nxt;
      r_target  <= w_target_nxt;
      r_disp    <= w_disp_nxt;
      r_fade    <= w_fade_nxt;
      r_init    <= w_init_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign display_state = r_disp;
  assign fade_level    = r_fade;
  assign level_init    = r_init;
  assign busy          = r_busy;

endmodule

// File: tb/tb_state_display_sync.sv
// Directed bench for state_display_sync with default parameters
// (FADE_MAX = 15, two frame ticks per fade step).
module tb_state_display_sync;
  import state_display_sync_pkg::*;

  logic       clk_40 = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst    = 1'b0;
  g_state     game_state = START;
  logic       vblnk  = 1'b0;
  g_state     display_state;
  logic [3:0] fade_level;
  logic       level_init;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  state_display_sync #(
    .FADE_BITS      (4),
    .FRAMES_PER_STEP(2)
  ) dut (
    .clk_40       (clk_40),
    .rst          (rst),
    .game_state   (game_state),
    .vblnk        (vblnk),
    .display_state(display_state),
    .fade_level   (fade_level),
    .level_init   (level_init),
    .busy         (busy)
  );

  initial begin
    wait (clk_en);
    forever #5 clk_40 = ~clk_40;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_40);
      #1;
    end
  endtask

  // Each pulse: one low cycle, then a one-cycle high; returns just after the tick edge.
  task automatic pulse(input int n);
    repeat (n) begin
      vblnk = 1'b0;
      cyc(1);
      vblnk = 1'b1;
      cyc(1);
      vblnk = 1'b0;
    end
  endtask

  initial begin
    // Reset with no clock running
    #1 rst = 1'b1;
    #1;
    chk("rst_disp", 32'(display_state), 32'(START));
    chk("rst_fade", 32'(fade_level), 32'd15);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init", 32'(level_init), 32'd0);
    clk_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // START -> LEVEL_1, with a tick coinciding with FADE_OUT entry
    game_state = LEVEL_1;
    vblnk = 1'b1;
    cyc(1);
    vblnk = 1'b0;
    chk("s2l_busy", 32'(busy), 32'd1);
    pulse(1);
    chk("s2l_entry_tick_ignored", 32'(fade_level), 32'd15);
    pulse(1);
    chk("s2l_first_step", 32'(fade_level), 32'd14);
    pulse(28);
    chk("s2l_black", 32'(fade_level), 32'd0);
    chk("s2l_disp_before_swap", 32'(display_state), 32'(START));
    cyc(1);
    chk("s2l_in_swap_disp", 32'(display_state), 32'(START));
    cyc(1);
    chk("s2l_swap_disp", 32'(display_state), 32'(LEVEL_1));
    chk("s2l_init_hi", 32'(level_init), 32'd1);
    cyc(1);
    chk("s2l_init_lo", 32'(level_init), 32'd0);
    pulse(2);
    chk("s2l_fadein_step", 32'(fade_level), 32'd1);
    pulse(28);
    chk("s2l_full", 32'(fade_level), 32'd15);
    chk("s2l_busy_end", 32'(busy), 32'd1);
    cyc(1);
    chk("s2l_idle", 32'(busy), 32'd0);

    // Long vblank during FADE_OUT, then retarget FINISH -> START at level 9
    game_state = FINISH;
    cyc(1);
    chk("lv_busy", 32'(busy), 32'd1);
    vblnk = 1'b1;
    cyc(500);
    chk("lv_hold", 32'(fade_level), 32'd15);
    vblnk = 1'b0;
    pulse(1);
    chk("lv_after", 32'(fade_level), 32'd14);
    pulse(10);
    chk("rt_at9", 32'(fade_level), 32'd9);
    game_state = START;
    pulse(18);
    chk("rt_black", 32'(fade_level), 32'd0);
    cyc(2);
    chk("rt_disp", 32'(display_state), 32'(START));
    chk("rt_init", 32'(level_init), 32'd0);
    pulse(30);
    chk("rt_full", 32'(fade_level), 32'd15);
    cyc(2);
    chk("rt_idle", 32'(busy), 32'd0);

    // Change during FADE_IN
    game_state = LEVEL_1;
    cyc(1);
    pulse(30);
    cyc(2);
    chk("fi_disp", 32'(display_state), 32'(LEVEL_1));
    chk("fi_init", 32'(level_init), 32'd1);
    pulse(14);
    chk("fi_at7", 32'(fade_level), 32'd7);
    game_state = START;
    pulse(16);
    chk("fi_full", 32'(fade_level), 32'd15);
    chk("fi_busy_hi", 32'(busy), 32'd1);
    cyc(1);
    chk("fi_busy_gap", 32'(busy), 32'd0);
    cyc(1);
    chk("fi_busy_again", 32'(busy), 32'd1);
    pulse(30);
    cyc(2);
    chk("fi_final_disp", 32'(display_state), 32'(START));
    chk("fi_final_init", 32'(level_init), 32'd0);
    pulse(30);
    cyc(1);
    chk("fi_final_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-FADE_OUT
    game_state = FINISH;
    cyc(1);
    pulse(20);
    chk("ar_at5", 32'(fade_level), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("ar_fade", 32'(fade_level), 32'd15);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_disp", 32'(display_state), 32'(START));
    chk("ar_init", 32'(level_init), 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("ar_restart", 32'(busy), 32'd1);
    chk("ar_restart_fade", 32'(fade_level), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
